// File: rtl/rom_load_bridge.sv
// rom_load_bridge: buffers the hps_io ioctl download stream into a small
// {addr,data} FIFO and drains it into the ddram toggle-handshake write port.
//
// Ports:
//   clk_sys, reset          system clock, synchronous active-high reset
//   ioctl_download          download active level from hps_io
//   ioctl_wr/addr/dout      1-cycle write strobe with address and data
//   ioctl_wait              backpressure, raised when FIFO headroom runs low
//   wraddr/din              ddram write address/data, held while outstanding
//   we_req/we_ack           toggle request / acknowledge pair
//   busy                    FIFO non-empty or request outstanding
//   done                    1-cycle pulse once a finished download drains
//   overflow                sticky dropped-word flag
//   word_count              words accepted since download start
module rom_load_bridge #(
  parameter int AW       = 25,
  parameter int DW       = 16,
  parameter int DEPTH    = 8,
  parameter int HEADROOM = 2,
  parameter int SWAP     = 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [DW-1:0] ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-1:0] wraddr,
  output logic [DW-1:0] din,
  output logic          we_req,
  input  logic          we_ack,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [AW-1:0] word_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NB = DW / 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;

  state_t state;
  state_t state_d;

  logic dl_q;
  logic armed;
  logic rise;
  logic fall;
  logic empty;
  logic full;
  logic push;
  logic drop;
  logic pop;

  function automatic logic [DW-1:0] swap_bytes(
    input logic [DW-1:0] d
  );
    logic [DW-1:0] r;
    r = d;
    if (SWAP != 0) begin
      for (int k = 0; k < NB; k++) begin
        r[8*k +: 8] = d[8*(NB-1-k) +: 8];
      end
    end
    return r;
  endfunction

  assign rise  = ioctl_download & ~dl_q;
  assign fall  = ~ioctl_download & dl_q;
  assign empty = (cnt == '0);

  // A download edge flushes the FIFO in the same cycle, so a write
  // arriving with the edge always sees an empty FIFO.
  assign full = ~rise & (cnt == CW'(DEPTH));
  assign push = ioctl_wr & ~full;
  assign drop = ioctl_wr & full;
  assign head = mem[rp];

  assign ioctl_wait = (CW'(DEPTH) - cnt) <= CW'(HEADROOM);
  assign busy       = ~empty | (state == S_BUSY);
  assign done       = armed & empty & (state == S_IDLE);

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        // Never pop an entry that the download edge is discarding.
        if (!empty && !rise) begin
          pop     = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (we_ack == we_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state  <= S_IDLE;
      we_req <= we_ack;
      wraddr <= '0;
      din    <= '0;
    end else begin
      state <= state_d;
      if (pop) begin
        wraddr <= head.addr;
        din    <= swap_bytes(head.data);
        we_req <= ~we_req;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[rise ? '0 : wp] <= '{addr: ioctl_addr, data: ioctl_dout};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (rise) begin
      wp  <= push ? PW'(1) : '0;
      rp  <= '0;
      cnt <= push ? CW'(1) : '0;
    end else begin
      if (push) begin
        wp <= wp + PW'(1);
      end
      if (pop) begin
        rp <= rp + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q       <= 1'b0;
      armed      <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      dl_q <= ioctl_download;
      if (rise) begin
        overflow   <= 1'b0;
        word_count <= push ? AW'(1) : '0;
      end else begin
        if (drop) begin
          overflow <= 1'b1;
        end
        if (push) begin
          word_count <= word_count + AW'(1);
        end
      end
      unique case (1'b1)
        rise:    armed <= 1'b0;
        fall:    armed <= 1'b1;
        done:    armed <= 1'b0;
        default: armed <= armed;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_load_bridge.sv
// tb_rom_load_bridge: directed and randomized checks of rom_load_bridge
// against a queue-based model of the download/drain behaviour.
module tb_rom_load_bridge;

  localparam int AW       = 25;
  localparam int DW       = 16;
  localparam int DEPTH    = 8;
  localparam int HEADROOM = 2;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [DW-1:0] ioctl_dout = '0;
  logic          ioctl_wait;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] din;
  logic          we_req;
  logic          we_ack = 1'b0;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW-1:0] word_count;

  rom_load_bridge #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .HEADROOM(HEADROOM), .SWAP(1)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .wraddr(wraddr),
    .din(din),
    .we_req(we_req),
    .we_ack(we_ack),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            m_busy = 0;
  bit            m_req = 0;
  bit            m_ovf = 0;
  bit            m_armed = 0;
  bit            m_dlp = 0;
  logic [AW-1:0] m_wraddr = '0;
  logic [AW-1:0] m_wc = '0;
  logic [DW-1:0] m_din = '0;
  bit            chk_en = 0;

  initial begin : model
    bit   rise, fall, pop, was_busy, done_now;
    int   n0;
    ent_t e;
    forever begin
      @(posedge clk_sys);
      if (reset) begin
        mq.delete();
        m_busy   = 0;
        m_req    = we_ack;
        m_ovf    = 0;
        m_wc     = '0;
        m_armed  = 0;
        m_dlp    = 0;
        m_wraddr = '0;
        m_din    = '0;
      end else begin
        rise     = ioctl_download && !m_dlp;
        fall     = !ioctl_download && m_dlp;
        n0       = mq.size();
        was_busy = m_busy;
        done_now = m_armed && n0 == 0 && !was_busy;
        if (was_busy && we_ack == m_req) m_busy = 0;
        pop = !was_busy && n0 > 0 && !rise;
        if (pop) begin
          e        = mq.pop_front();
          m_wraddr = e.a;
          m_din    = {e.d[7:0], e.d[15:8]};
          m_req    = !m_req;
          m_busy   = 1;
        end
        if (rise) begin
          mq.delete();
          m_ovf = 0;
          m_wc  = '0;
        end
        if (ioctl_wr) begin
          if ((rise ? 0 : n0) < DEPTH) begin
            mq.push_back('{a: ioctl_addr, d: ioctl_dout});
            m_wc = m_wc + 1;
          end else begin
            m_ovf = 1;
          end
        end
        if (rise) m_armed = 0;
        else if (fall) m_armed = 1;
        else if (done_now) m_armed = 0;
        m_dlp = ioctl_download;
      end
    end
  end

  initial begin : compare
    int n;
    forever begin
      @(negedge clk_sys);
      if (chk_en) begin
        n = mq.size();
        chk("ioctl_wait", ioctl_wait, 32'((DEPTH - n) <= HEADROOM));
        chk("busy", busy, 32'(n != 0 || m_busy));
        chk("done", done, 32'(m_armed && n == 0 && !m_busy));
        chk("we_req", we_req, 32'(m_req));
        chk("wraddr", wraddr, 32'(m_wraddr));
        chk("din", din, 32'(m_din));
        chk("overflow", overflow, 32'(m_ovf));
        chk("word_count", word_count, 32'(m_wc));
      end
    end
  end

  bit hold = 0;
  int lat = 0;
  int lat_cnt = 0;
  int ack_toggles = 0;

  task automatic tick();
    @(posedge clk_sys);
    #1;
    ioctl_wr = 1'b0;
    if (reset) begin
      lat_cnt = 0;
    end else if (we_req !== we_ack) begin
      if (!hold) begin
        if (lat_cnt >= lat) begin
          we_ack = we_req;
          ack_toggles++;
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end
    end else begin
      lat_cnt = 0;
    end
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
  endtask

  task automatic wr_rand();
    wr1(AW'($urandom), DW'($urandom));
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300 && (busy || we_req !== we_ack); i++) tick();
    chk(nm, busy, 0);
  endtask

  int sent;
  int t0;
  int ndone;
  int n57;

  initial begin
    tick();
    chk_en = 1;
    tick();
    tick();
    chk("rst_wc", word_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_req", we_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wraddr", wraddr, 0);
    chk("rst_din", din, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    ioctl_download = 1'b1;
    tick();

    lat = 3;
    wr1(25'h10, 16'h1234);
    chk("t1_req_early", we_req, 0);
    tick();
    chk("t1_wraddr", wraddr, 32'h10);
    chk("t1_din", din, 32'h3412);
    chk("t1_req", we_req, 1);
    chk("t1_busy", busy, 1);
    drain("t1_idle");

    hold = 1;
    lat = 1;
    sent = 0;
    for (int i = 0; i < 30 && sent < 10 && !ioctl_wait; i++) begin
      wr1(AW'(32'h100 + sent), DW'(32'hA000 + sent));
      sent++;
    end
    chk("t2_sent_held", sent, 7);
    chk("t2_wait", ioctl_wait, 1);
    tick();
    tick();
    hold = 0;
    for (int i = 0; i < 200 && sent < 10; i++) begin
      if (!ioctl_wait) begin
        wr1(AW'(32'h100 + sent), DW'(32'hA000 + sent));
        sent++;
      end else begin
        tick();
      end
    end
    chk("t2_ovf", overflow, 0);
    drain("t2_drain");
    chk("t2_wc", word_count, 11);

    hold = 1;
    wr_rand();
    tick();
    tick();
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    for (int i = 0; i < 9; i++) wr_rand();
    chk("t3_wc", word_count, 8);
    chk("t3_ovf", overflow, 1);

    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
    chk("t4_wc", word_count, 0);
    chk("t4_ovf", overflow, 0);
    chk("t4_busy", busy, 1);
    chk("t4_wait", ioctl_wait, 0);
    t0 = ack_toggles;
    hold = 0;
    drain("t4_drain");
    tick();
    tick();
    chk("t4_acks", ack_toggles - t0, 1);

    hold = 1;
    lat = 0;
    wr_rand();
    tick();
    tick();
    for (int i = 0; i < 7; i++) wr_rand();
    hold = 0;
    n57 = 0;
    for (int i = 0; i < 60; i++) begin
      lat = $urandom_range(0, 2);
      if (!m_busy && mq.size() > 0) begin
        if (mq.size() == 7) n57++;
        wr_rand();
      end else if (mq.size() < 7) begin
        wr_rand();
      end else begin
        tick();
      end
    end
    chk("t5_ovf", overflow, 0);
    chk("t5_wait", ioctl_wait, 1);
    drain("t5_drain");

    lat = 1;
    hold = 1;
    wr_rand();
    wr_rand();
    ioctl_download = 1'b0;
    tick();
    hold = 0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("t6_done_once", ndone, 1);

    ioctl_download = 1'b1;
    tick();
    hold = 1;
    wr_rand();
    tick();
    tick();
    chk("rb_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    chk("rb_req_eq_ack", 32'(we_req ^ we_ack), 0);
    chk("rb_busy", busy, 0);
    chk("rb_wraddr", wraddr, 0);
    chk("rb_din", din, 0);
    chk("rb_wc", word_count, 0);
    chk("rb_ovf", overflow, 0);
    chk("rb_done", done, 0);
    reset = 1'b0;
    hold = 0;
    tick();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) hold = !hold;
      lat = $urandom_range(0, 3);
      if ($urandom_range(0, 39) == 0) ioctl_download = !ioctl_download;
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 2) != 0 &&
          ($urandom_range(0, 3) == 0 || !ioctl_wait)) begin
        wr_rand();
      end else begin
        tick();
      end
    end
    reset = 1'b0;
    hold = 0;
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
